// File: rtl/icache_refill_ctrl_pkg.sv
// Shared types for the icache refill stage: MSHR entry layout, downstream refill beat,
// refill FSM encoding and the work register captured at lookup.
package icache_refill_ctrl_pkg;

  localparam int unsigned REFILL_BUF_DEPTH_DEF = 2;
  localparam logic [4:0]  PREFETCH_OPCODE      = 5'h03;

  typedef struct packed {
    logic [17:0] tag;
    logic [7:0]  index;
    logic [5:0]  offset;
  } addr_t;

  typedef struct packed {
    logic [4:0] txnid;
    logic [4:0] opcode;
    addr_t      addr;
  } req_t;

  typedef struct packed {
    req_t req;
    logic dest_way;
  } entry_data_t;

  typedef struct packed {
    logic [9:0]   meta;
    logic [3:0]   entry_idx;
    logic [511:0] data;
  } downstream_rxdat_t;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOOKUP  = 3'd1,
    WRITE   = 3'd2,
    RESP    = 3'd3,
    RELEASE = 3'd4
  } refill_fsm_e;

  typedef struct packed {
    entry_data_t  ent;
    logic [511:0] data;
    logic [3:0]   idx;
  } refill_work_t;

  function automatic logic is_prefetch(input entry_data_t ent);
    return (ent.req.opcode == PREFETCH_OPCODE);
  endfunction

endpackage

// File: rtl/icache_refill_ctrl_buf.sv
// Synchronous FIFO holding returned refill lines until the refill FSM consumes them.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module icache_refill_buf
  import icache_refill_ctrl_pkg::*;
#(
  parameter int unsigned DEPTH = REFILL_BUF_DEPTH_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  downstream_rxdat_t push_data,
  input  logic              pop,
  output downstream_rxdat_t head_data,
  output logic              empty,
  output logic              full
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0]       wr_ptr_q, wr_ptr_d;
  logic [AW:0]       rd_ptr_q, rd_ptr_d;
  downstream_rxdat_t mem_q [DEPTH];
  logic              push_en;
  logic              pop_en;

  assign empty     = (wr_ptr_q == rd_ptr_q);
  assign full      = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign push_en   = push && !full;
  assign pop_en    = pop && !empty;
  assign head_data = mem_q[rd_ptr_q[AW-1:0]];

  // Pointer advance.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_en) begin
      wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, 1'b1};
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_en) begin
      rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, 1'b1};
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
  end

  // Pointer registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage; contents are don't-care while the pointers mark them empty.
  always_ff @(posedge clk) begin
    if (push_en) begin
      mem_q[wr_ptr_q[AW-1:0]] <= push_data;
    end
  end

endmodule

// File: rtl/icache_refill_ctrl.sv
// Refill stage: buffers downstream lines, writes data/tag RAMs, returns the line upstream and
// releases the MSHR entry. Macro ICACHE_REFILL_BYPASS_EN overlaps the upstream response with the RAM writes.
module icache_refill_ctrl
  import icache_refill_ctrl_pkg::*;
#(
  parameter int unsigned REFILL_BUF_DEPTH = REFILL_BUF_DEPTH_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         rxdat_vld,
  output logic         rxdat_rdy,
  input  logic [525:0] rxdat_pld,
  output logic [3:0]   mshr_rd_idx,
  input  logic [42:0]  mshr_rd_pld,
  output logic         dataram_wr_vld,
  input  logic         dataram_wr_rdy,
  output logic         dataram_wr_way,
  output logic [7:0]   dataram_wr_index,
  output logic [511:0] dataram_wr_data,
  output logic         tagram_wr_vld,
  input  logic         tagram_wr_rdy,
  output logic         tagram_wr_way,
  output logic [7:0]   tagram_wr_index,
  output logic [17:0]  tagram_wr_tag,
  output logic         upstream_rsp_vld,
  input  logic         upstream_rsp_rdy,
  output logic [4:0]   upstream_rsp_txnid,
  output logic [511:0] upstream_rsp_data,
  output logic         mshr_release_vld,
  output logic [3:0]   mshr_release_idx
);

  refill_fsm_e       state_q, state_d;
  refill_work_t      work_q, work_d;
  logic              data_done_q, data_done_d;
  logic              tag_done_q, tag_done_d;
`ifdef ICACHE_REFILL_BYPASS_EN
  logic              rsp_done_q, rsp_done_d;
`endif
  logic              buf_push;
  logic              buf_pop;
  logic              buf_empty;
  logic              buf_full;
  downstream_rxdat_t buf_head;
  logic              is_pf;
  logic              unused_bits;

  icache_refill_buf #(
    .DEPTH (REFILL_BUF_DEPTH)
  ) u_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (buf_push),
    .push_data (downstream_rxdat_t'(rxdat_pld)),
    .pop       (buf_pop),
    .head_data (buf_head),
    .empty     (buf_empty),
    .full      (buf_full)
  );

  assign rxdat_rdy   = !buf_full;
  assign buf_push    = rxdat_vld && !buf_full;
  assign mshr_rd_idx = buf_empty ? 4'd0 : buf_head.entry_idx;
  assign is_pf       = is_prefetch(work_q.ent);
  assign unused_bits = ^{work_q.ent.req.addr.offset, buf_head.meta};

  assign dataram_wr_way     = work_q.ent.dest_way;
  assign dataram_wr_index   = work_q.ent.req.addr.index;
  assign dataram_wr_data    = work_q.data;
  assign tagram_wr_way      = work_q.ent.dest_way;
  assign tagram_wr_index    = work_q.ent.req.addr.index;
  assign tagram_wr_tag      = work_q.ent.req.addr.tag;
  assign upstream_rsp_txnid = work_q.ent.req.txnid;
  assign upstream_rsp_data  = work_q.data;
  assign mshr_release_idx   = work_q.idx;

  // Next state, work capture, done flags and handshake outputs.
  always_comb begin
    state_d          = state_q;
    work_d           = work_q;
    data_done_d      = data_done_q;
    tag_done_d       = tag_done_q;
`ifdef ICACHE_REFILL_BYPASS_EN
    rsp_done_d       = rsp_done_q;
`endif
    dataram_wr_vld   = 1'b0;
    tagram_wr_vld    = 1'b0;
    upstream_rsp_vld = 1'b0;
    mshr_release_vld = 1'b0;
    buf_pop          = 1'b0;
    case (state_q)
      IDLE: begin
        // A line arriving this cycle is readable at the head next cycle.
        if (!buf_empty || buf_push) begin
          state_d = LOOKUP;
        end else begin
          state_d = IDLE;
        end
      end
      LOOKUP: begin
        work_d.ent  = entry_data_t'(mshr_rd_pld);
        work_d.data = buf_head.data;
        work_d.idx  = buf_head.entry_idx;
        data_done_d = 1'b0;
        tag_done_d  = 1'b0;
`ifdef ICACHE_REFILL_BYPASS_EN
        rsp_done_d  = 1'b0;
`endif
        state_d     = WRITE;
      end
      WRITE: begin
        dataram_wr_vld = !data_done_q;
        tagram_wr_vld  = !tag_done_q;
        data_done_d    = data_done_q || (dataram_wr_vld && dataram_wr_rdy);
        tag_done_d     = tag_done_q || (tagram_wr_vld && tagram_wr_rdy);
`ifdef ICACHE_REFILL_BYPASS_EN
        upstream_rsp_vld = !is_pf && !rsp_done_q;
        rsp_done_d       = rsp_done_q || (upstream_rsp_vld && upstream_rsp_rdy);
        if (data_done_d && tag_done_d && (rsp_done_d || is_pf)) begin
          state_d = RELEASE;
        end else begin
          state_d = WRITE;
        end
`else
        if (data_done_d && tag_done_d) begin
          state_d = is_pf ? RELEASE : RESP;
        end else begin
          state_d = WRITE;
        end
`endif
      end
      RESP: begin
        upstream_rsp_vld = 1'b1;
        if (upstream_rsp_rdy) begin
          state_d = RELEASE;
        end else begin
          state_d = RESP;
        end
      end
      RELEASE: begin
        mshr_release_vld = 1'b1;
        buf_pop          = 1'b1;
        state_d          = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, work register and done flags.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      work_q      <= '0;
      data_done_q <= 1'b0;
      tag_done_q  <= 1'b0;
`ifdef ICACHE_REFILL_BYPASS_EN
      rsp_done_q  <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      work_q      <= work_d;
      data_done_q <= data_done_d;
      tag_done_q  <= tag_done_d;
`ifdef ICACHE_REFILL_BYPASS_EN
      rsp_done_q  <= rsp_done_d;
`endif
    end
  end

endmodule

// File: tb/tb_icache_refill_ctrl.sv
// Directed self-checking bench for icache_refill_ctrl; inputs driven and outputs sampled on the falling edge.
module tb_icache_refill_ctrl;
  import icache_refill_ctrl_pkg::*;

  logic         clk;
  logic         rst_n;
  logic         rxdat_vld;
  logic         rxdat_rdy;
  logic [525:0] rxdat_pld;
  logic [3:0]   mshr_rd_idx;
  logic [42:0]  mshr_rd_pld;
  logic         dataram_wr_vld;
  logic         dataram_wr_rdy;
  logic         dataram_wr_way;
  logic [7:0]   dataram_wr_index;
  logic [511:0] dataram_wr_data;
  logic         tagram_wr_vld;
  logic         tagram_wr_rdy;
  logic         tagram_wr_way;
  logic [7:0]   tagram_wr_index;
  logic [17:0]  tagram_wr_tag;
  logic         upstream_rsp_vld;
  logic         upstream_rsp_rdy;
  logic [4:0]   upstream_rsp_txnid;
  logic [511:0] upstream_rsp_data;
  logic         mshr_release_vld;
  logic [3:0]   mshr_release_idx;

  logic [42:0]  mshr_mem [16];
  int           n_pass;
  int           n_total;

  icache_refill_ctrl dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .rxdat_vld          (rxdat_vld),
    .rxdat_rdy          (rxdat_rdy),
    .rxdat_pld          (rxdat_pld),
    .mshr_rd_idx        (mshr_rd_idx),
    .mshr_rd_pld        (mshr_rd_pld),
    .dataram_wr_vld     (dataram_wr_vld),
    .dataram_wr_rdy     (dataram_wr_rdy),
    .dataram_wr_way     (dataram_wr_way),
    .dataram_wr_index   (dataram_wr_index),
    .dataram_wr_data    (dataram_wr_data),
    .tagram_wr_vld      (tagram_wr_vld),
    .tagram_wr_rdy      (tagram_wr_rdy),
    .tagram_wr_way      (tagram_wr_way),
    .tagram_wr_index    (tagram_wr_index),
    .tagram_wr_tag      (tagram_wr_tag),
    .upstream_rsp_vld   (upstream_rsp_vld),
    .upstream_rsp_rdy   (upstream_rsp_rdy),
    .upstream_rsp_txnid (upstream_rsp_txnid),
    .upstream_rsp_data  (upstream_rsp_data),
    .mshr_release_vld   (mshr_release_vld),
    .mshr_release_idx   (mshr_release_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // MSHR storage read combinationally, as the real MSHR does.
  always_comb mshr_rd_pld = mshr_mem[mshr_rd_idx];

  function automatic logic [525:0] mk_rx(input logic [3:0] idx, input logic [511:0] d);
    return {10'h000, idx, d};
  endfunction

  function automatic logic [42:0] mk_ent(input logic [4:0] txnid, input logic [4:0] opc,
                                         input logic [17:0] tag, input logic [7:0] index,
                                         input logic way);
    return {txnid, opc, tag, index, 6'h00, way};
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    rxdat_vld = 1'b0;
    rxdat_pld = '0;
    dataram_wr_rdy = 1'b1;
    tagram_wr_rdy = 1'b1;
    upstream_rsp_rdy = 1'b1;
    for (int i = 0; i < 16; i++) mshr_mem[i] = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_total++; if (dataram_wr_vld !== 1'b0) $display("FAIL rst_dvld got=%0h exp=0", dataram_wr_vld); else n_pass++;
    n_total++; if (tagram_wr_vld !== 1'b0) $display("FAIL rst_tvld got=%0h exp=0", tagram_wr_vld); else n_pass++;
    n_total++; if (upstream_rsp_vld !== 1'b0) $display("FAIL rst_rsp got=%0h exp=0", upstream_rsp_vld); else n_pass++;
    n_total++; if (mshr_release_vld !== 1'b0) $display("FAIL rst_rel got=%0h exp=0", mshr_release_vld); else n_pass++;
    n_total++; if (rxdat_rdy !== 1'b1) $display("FAIL rst_rxrdy got=%0h exp=1", rxdat_rdy); else n_pass++;
    n_total++; if (mshr_rd_idx !== 4'd0) $display("FAIL rst_rdidx got=%0h exp=0", mshr_rd_idx); else n_pass++;
    n_total++; if (mshr_release_idx !== 4'd0) $display("FAIL rst_relidx got=%0h exp=0", mshr_release_idx); else n_pass++;
    n_total++; if (dataram_wr_data !== 512'd0) $display("FAIL rst_ddata got=%0h exp=0", dataram_wr_data); else n_pass++;
    rst_n = 1'b1;
    @(negedge clk);
    n_total++; if (dataram_wr_vld !== 1'b0) $display("FAIL rst_idle_dvld got=%0h exp=0", dataram_wr_vld); else n_pass++;
  endtask

`ifdef ICACHE_REFILL_BYPASS_EN
  task automatic test_bypass();
    logic [511:0] d1;
    d1 = {16{32'hA5A5_0001}};
    mshr_mem[3] = mk_ent(5'd7, 5'h00, 18'h01234, 8'h5A, 1'b1);
    @(negedge clk);
    rxdat_vld = 1'b1;
    rxdat_pld = mk_rx(4'd3, d1);
    n_total++; if (rxdat_rdy !== 1'b1) $display("FAIL byp_rxrdy got=%0h exp=1", rxdat_rdy); else n_pass++;
    @(negedge clk);
    rxdat_vld = 1'b0;
    n_total++; if (mshr_rd_idx !== 4'd3) $display("FAIL byp_rdidx got=%0h exp=3", mshr_rd_idx); else n_pass++;
    @(negedge clk);
    n_total++; if (dataram_wr_vld !== 1'b1) $display("FAIL byp_dvld got=%0h exp=1", dataram_wr_vld); else n_pass++;
    n_total++; if (tagram_wr_vld !== 1'b1) $display("FAIL byp_tvld got=%0h exp=1", tagram_wr_vld); else n_pass++;
    n_total++; if (upstream_rsp_vld !== 1'b1) $display("FAIL byp_rsp got=%0h exp=1", upstream_rsp_vld); else n_pass++;
    n_total++; if (upstream_rsp_txnid !== 5'd7) $display("FAIL byp_txnid got=%0h exp=7", upstream_rsp_txnid); else n_pass++;
    n_total++; if (upstream_rsp_data !== d1) $display("FAIL byp_rdata got=%0h exp=%0h", upstream_rsp_data, d1); else n_pass++;
    n_total++; if (tagram_wr_tag !== 18'h01234) $display("FAIL byp_tag got=%0h exp=1234", tagram_wr_tag); else n_pass++;
    @(negedge clk);
    n_total++; if (mshr_release_vld !== 1'b1) $display("FAIL byp_rel got=%0h exp=1", mshr_release_vld); else n_pass++;
    n_total++; if (mshr_release_idx !== 4'd3) $display("FAIL byp_relidx got=%0h exp=3", mshr_release_idx); else n_pass++;
    n_total++; if (upstream_rsp_vld !== 1'b0) $display("FAIL byp_rsp_drop got=%0h exp=0", upstream_rsp_vld); else n_pass++;
    @(negedge clk);
    n_total++; if (mshr_release_vld !== 1'b0) $display("FAIL byp_rel_pulse got=%0h exp=0", mshr_release_vld); else n_pass++;
  endtask
`else
  task automatic test_single();
    logic [511:0] d1;
    d1 = {16{32'hA5A5_0001}};
    mshr_mem[3] = mk_ent(5'd7, 5'h00, 18'h01234, 8'h5A, 1'b1);
    @(negedge clk);
    rxdat_vld = 1'b1;
    rxdat_pld = mk_rx(4'd3, d1);
    n_total++; if (rxdat_rdy !== 1'b1) $display("FAIL s_rxrdy got=%0h exp=1", rxdat_rdy); else n_pass++;
    @(negedge clk);
    rxdat_vld = 1'b0;
    n_total++; if (dataram_wr_vld !== 1'b0) $display("FAIL s_lookup_dvld got=%0h exp=0", dataram_wr_vld); else n_pass++;
    n_total++; if (mshr_rd_idx !== 4'd3) $display("FAIL s_rdidx got=%0h exp=3", mshr_rd_idx); else n_pass++;
    @(negedge clk);
    n_total++; if (dataram_wr_vld !== 1'b1) $display("FAIL s_dvld got=%0h exp=1", dataram_wr_vld); else n_pass++;
    n_total++; if (tagram_wr_vld !== 1'b1) $display("FAIL s_tvld got=%0h exp=1", tagram_wr_vld); else n_pass++;
    n_total++; if (dataram_wr_way !== 1'b1) $display("FAIL s_dway got=%0h exp=1", dataram_wr_way); else n_pass++;
    n_total++; if (dataram_wr_index !== 8'h5A) $display("FAIL s_dindex got=%0h exp=5a", dataram_wr_index); else n_pass++;
    n_total++; if (dataram_wr_data !== d1) $display("FAIL s_ddata got=%0h exp=%0h", dataram_wr_data, d1); else n_pass++;
    n_total++; if (tagram_wr_way !== 1'b1) $display("FAIL s_tway got=%0h exp=1", tagram_wr_way); else n_pass++;
    n_total++; if (tagram_wr_index !== 8'h5A) $display("FAIL s_tindex got=%0h exp=5a", tagram_wr_index); else n_pass++;
    n_total++; if (tagram_wr_tag !== 18'h01234) $display("FAIL s_tag got=%0h exp=1234", tagram_wr_tag); else n_pass++;
    n_total++; if (upstream_rsp_vld !== 1'b0) $display("FAIL s_rsp_early got=%0h exp=0", upstream_rsp_vld); else n_pass++;
    @(negedge clk);
    n_total++; if (upstream_rsp_vld !== 1'b1) $display("FAIL s_rsp got=%0h exp=1", upstream_rsp_vld); else n_pass++;
    n_total++; if (upstream_rsp_txnid !== 5'd7) $display("FAIL s_txnid got=%0h exp=7", upstream_rsp_txnid); else n_pass++;
    n_total++; if (upstream_rsp_data !== d1) $display("FAIL s_rdata got=%0h exp=%0h", upstream_rsp_data, d1); else n_pass++;
    n_total++; if (dataram_wr_vld !== 1'b0) $display("FAIL s_dvld_drop got=%0h exp=0", dataram_wr_vld); else n_pass++;
    n_total++; if (tagram_wr_vld !== 1'b0) $display("FAIL s_tvld_drop got=%0h exp=0", tagram_wr_vld); else n_pass++;
    @(negedge clk);
    n_total++; if (mshr_release_vld !== 1'b1) $display("FAIL s_rel got=%0h exp=1", mshr_release_vld); else n_pass++;
    n_total++; if (mshr_release_idx !== 4'd3) $display("FAIL s_relidx got=%0h exp=3", mshr_release_idx); else n_pass++;
    n_total++; if (upstream_rsp_vld !== 1'b0) $display("FAIL s_rsp_drop got=%0h exp=0", upstream_rsp_vld); else n_pass++;
    @(negedge clk);
    n_total++; if (mshr_release_vld !== 1'b0) $display("FAIL s_rel_pulse got=%0h exp=0", mshr_release_vld); else n_pass++;
  endtask

  task automatic test_backpressure();
    logic [511:0] d2;
    d2 = {8{64'hDEAD_BEEF_0BAD_F00D}};
    mshr_mem[5] = mk_ent(5'd9, 5'h00, 18'h2ABCD, 8'hC3, 1'b0);
    dataram_wr_rdy = 1'b0;
    @(negedge clk);
    rxdat_vld = 1'b1;
    rxdat_pld = mk_rx(4'd5, d2);
    @(negedge clk);
    rxdat_vld = 1'b0;
    @(negedge clk);
    n_total++; if (dataram_wr_vld !== 1'b1) $display("FAIL bp_dvld got=%0h exp=1", dataram_wr_vld); else n_pass++;
    n_total++; if (tagram_wr_vld !== 1'b1) $display("FAIL bp_tvld got=%0h exp=1", tagram_wr_vld); else n_pass++;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      n_total++; if (tagram_wr_vld !== 1'b0) $display("FAIL bp_tvld_drop c%0d got=%0h exp=0", i, tagram_wr_vld); else n_pass++;
      n_total++; if (dataram_wr_vld !== 1'b1) $display("FAIL bp_dvld_hold c%0d got=%0h exp=1", i, dataram_wr_vld); else n_pass++;
      n_total++; if (dataram_wr_index !== 8'hC3) $display("FAIL bp_dindex c%0d got=%0h exp=c3", i, dataram_wr_index); else n_pass++;
      n_total++; if (dataram_wr_way !== 1'b0) $display("FAIL bp_dway c%0d got=%0h exp=0", i, dataram_wr_way); else n_pass++;
      n_total++; if (dataram_wr_data !== d2) $display("FAIL bp_ddata c%0d got=%0h exp=%0h", i, dataram_wr_data, d2); else n_pass++;
      n_total++; if (upstream_rsp_vld !== 1'b0) $display("FAIL bp_rsp_early c%0d got=%0h exp=0", i, upstream_rsp_vld); else n_pass++;
    end
    dataram_wr_rdy = 1'b1;
    @(negedge clk);
    n_total++; if (dataram_wr_vld !== 1'b0) $display("FAIL bp_dvld_done got=%0h exp=0", dataram_wr_vld); else n_pass++;
    n_total++; if (upstream_rsp_vld !== 1'b1) $display("FAIL bp_rsp got=%0h exp=1", upstream_rsp_vld); else n_pass++;
    n_total++; if (upstream_rsp_txnid !== 5'd9) $display("FAIL bp_txnid got=%0h exp=9", upstream_rsp_txnid); else n_pass++;
    @(negedge clk);
    n_total++; if (mshr_release_vld !== 1'b1) $display("FAIL bp_rel got=%0h exp=1", mshr_release_vld); else n_pass++;
    n_total++; if (mshr_release_idx !== 4'd5) $display("FAIL bp_relidx got=%0h exp=5", mshr_release_idx); else n_pass++;
    @(negedge clk);
  endtask
`endif

  task automatic test_prefetch();
    logic seen_rsp;
    seen_rsp = 1'b0;
    mshr_mem[8] = mk_ent(5'd2, PREFETCH_OPCODE, 18'h00003, 8'h11, 1'b1);
    tagram_wr_rdy = 1'b0;
    @(negedge clk);
    rxdat_vld = 1'b1;
    rxdat_pld = mk_rx(4'd8, {32{16'h5A5A}});
    @(negedge clk);
    rxdat_vld = 1'b0;
    seen_rsp = seen_rsp | upstream_rsp_vld;
    @(negedge clk);
    seen_rsp = seen_rsp | upstream_rsp_vld;
    n_total++; if (dataram_wr_vld !== 1'b1) $display("FAIL pf_dvld got=%0h exp=1", dataram_wr_vld); else n_pass++;
    n_total++; if (tagram_wr_vld !== 1'b1) $display("FAIL pf_tvld got=%0h exp=1", tagram_wr_vld); else n_pass++;
    @(negedge clk);
    seen_rsp = seen_rsp | upstream_rsp_vld;
    n_total++; if (dataram_wr_vld !== 1'b0) $display("FAIL pf_dvld_drop got=%0h exp=0", dataram_wr_vld); else n_pass++;
    n_total++; if (tagram_wr_vld !== 1'b1) $display("FAIL pf_tvld_hold got=%0h exp=1", tagram_wr_vld); else n_pass++;
    n_total++; if (mshr_release_vld !== 1'b0) $display("FAIL pf_rel_early got=%0h exp=0", mshr_release_vld); else n_pass++;
    tagram_wr_rdy = 1'b1;
    @(negedge clk);
    seen_rsp = seen_rsp | upstream_rsp_vld;
    n_total++; if (mshr_release_vld !== 1'b1) $display("FAIL pf_rel got=%0h exp=1", mshr_release_vld); else n_pass++;
    n_total++; if (mshr_release_idx !== 4'd8) $display("FAIL pf_relidx got=%0h exp=8", mshr_release_idx); else n_pass++;
    @(negedge clk);
    seen_rsp = seen_rsp | upstream_rsp_vld;
    n_total++; if (mshr_release_vld !== 1'b0) $display("FAIL pf_rel_pulse got=%0h exp=0", mshr_release_vld); else n_pass++;
    n_total++; if (seen_rsp !== 1'b0) $display("FAIL pf_no_rsp got=%0h exp=0", seen_rsp); else n_pass++;
  endtask

  task automatic test_full_buffer();
    logic [3:0] rel_q [$];
    logic [4:0] rsp_q [$];
    logic [3:0] exp_idx [3];
    logic [4:0] exp_txn [3];
    logic [3:0] got_idx;
    logic [4:0] got_txn;
    logic       c_pending;
    exp_idx[0] = 4'd1; exp_idx[1] = 4'd2; exp_idx[2] = 4'd4;
    exp_txn[0] = 5'd11; exp_txn[1] = 5'd12; exp_txn[2] = 5'd14;
    mshr_mem[1] = mk_ent(5'd11, 5'h00, 18'h00101, 8'h01, 1'b0);
    mshr_mem[2] = mk_ent(5'd12, 5'h00, 18'h00202, 8'h02, 1'b1);
    mshr_mem[4] = mk_ent(5'd14, 5'h00, 18'h00404, 8'h04, 1'b0);
    upstream_rsp_rdy = 1'b0;
    @(negedge clk);
    rxdat_vld = 1'b1;
    rxdat_pld = mk_rx(4'd1, {16{32'h1111_0001}});
    n_total++; if (rxdat_rdy !== 1'b1) $display("FAIL fb_rdy_a got=%0h exp=1", rxdat_rdy); else n_pass++;
    @(negedge clk);
    rxdat_pld = mk_rx(4'd2, {16{32'h2222_0002}});
    n_total++; if (rxdat_rdy !== 1'b1) $display("FAIL fb_rdy_b got=%0h exp=1", rxdat_rdy); else n_pass++;
    @(negedge clk);
    rxdat_pld = mk_rx(4'd4, {16{32'h4444_0004}});
    for (int i = 0; i < 4; i++) begin
      n_total++; if (rxdat_rdy !== 1'b0) $display("FAIL fb_full c%0d got=%0h exp=0", i, rxdat_rdy); else n_pass++;
      @(negedge clk);
    end
    upstream_rsp_rdy = 1'b1;
    c_pending = 1'b1;
    for (int cyc = 0; cyc < 40; cyc++) begin
      if (!c_pending) rxdat_vld = 1'b0;
      if (mshr_release_vld) rel_q.push_back(mshr_release_idx);
      if (upstream_rsp_vld && upstream_rsp_rdy) rsp_q.push_back(upstream_rsp_txnid);
      if (c_pending && rxdat_rdy) c_pending = 1'b0;
      @(negedge clk);
    end
    rxdat_vld = 1'b0;
    n_total++; if (c_pending !== 1'b0) $display("FAIL fb_c_accept got=%0h exp=0", c_pending); else n_pass++;
    n_total++; if (rel_q.size() != 3) $display("FAIL fb_rel_count got=%0d exp=3", rel_q.size()); else n_pass++;
    n_total++; if (rsp_q.size() != 3) $display("FAIL fb_rsp_count got=%0d exp=3", rsp_q.size()); else n_pass++;
    for (int i = 0; i < 3; i++) begin
      got_idx = (i < rel_q.size()) ? rel_q[i] : 4'hx;
      got_txn = (i < rsp_q.size()) ? rsp_q[i] : 5'hx;
      n_total++; if (got_idx !== exp_idx[i]) $display("FAIL fb_rel_order %0d got=%0h exp=%0h", i, got_idx, exp_idx[i]); else n_pass++;
      n_total++; if (got_txn !== exp_txn[i]) $display("FAIL fb_rsp_order %0d got=%0h exp=%0h", i, got_txn, exp_txn[i]); else n_pass++;
    end
  endtask

  task automatic test_reset_mid();
    logic seen_rel;
    logic seen_wr;
    seen_rel = 1'b0;
    seen_wr = 1'b0;
    mshr_mem[6] = mk_ent(5'd6, 5'h00, 18'h00606, 8'h66, 1'b1);
    dataram_wr_rdy = 1'b0;
    tagram_wr_rdy = 1'b0;
    @(negedge clk);
    rxdat_vld = 1'b1;
    rxdat_pld = mk_rx(4'd6, {16{32'h6666_0006}});
    @(negedge clk);
    rxdat_pld = mk_rx(4'd3, {16{32'h3333_0003}});
    @(negedge clk);
    rxdat_vld = 1'b0;
    n_total++; if (dataram_wr_vld !== 1'b1) $display("FAIL rm_in_write got=%0h exp=1", dataram_wr_vld); else n_pass++;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    n_total++; if (dataram_wr_vld !== 1'b0) $display("FAIL rm_dvld got=%0h exp=0", dataram_wr_vld); else n_pass++;
    n_total++; if (tagram_wr_vld !== 1'b0) $display("FAIL rm_tvld got=%0h exp=0", tagram_wr_vld); else n_pass++;
    n_total++; if (upstream_rsp_vld !== 1'b0) $display("FAIL rm_rsp got=%0h exp=0", upstream_rsp_vld); else n_pass++;
    n_total++; if (mshr_release_vld !== 1'b0) $display("FAIL rm_rel got=%0h exp=0", mshr_release_vld); else n_pass++;
    n_total++; if (rxdat_rdy !== 1'b1) $display("FAIL rm_rxrdy got=%0h exp=1", rxdat_rdy); else n_pass++;
    n_total++; if (mshr_rd_idx !== 4'd0) $display("FAIL rm_empty got=%0h exp=0", mshr_rd_idx); else n_pass++;
    dataram_wr_rdy = 1'b1;
    tagram_wr_rdy = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      seen_rel = seen_rel | mshr_release_vld;
      seen_wr = seen_wr | dataram_wr_vld | tagram_wr_vld;
    end
    n_total++; if (seen_rel !== 1'b0) $display("FAIL rm_no_release got=%0h exp=0", seen_rel); else n_pass++;
    n_total++; if (seen_wr !== 1'b0) $display("FAIL rm_no_write got=%0h exp=0", seen_wr); else n_pass++;
  endtask

  initial begin
    n_pass = 0;
    n_total = 0;
    test_reset();
`ifdef ICACHE_REFILL_BYPASS_EN
    test_bypass();
`else
    test_single();
    test_backpressure();
`endif
    test_prefetch();
    test_full_buffer();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
